krypton_vram_arbiter: RTL



---
 rtl/krypton_vga_pkg.sv | 32 +++
 rtl/krypton_scan_addrgen.sv | 42 ++++
 rtl/krypton_vram_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/krypton_vga_pkg.sv
// krypton_vga_pkg
// Shared VGA timing constants, framebuffer geometry and scanout slot phases
// for the krypton display path. Also provides the multiplier-free
// framebuffer address helper used by the scanout address generator.
package krypton_vga_pkg;

    localparam int ADDR_W = 16;

    localparam logic [9:0] H_VISIBLE = 10'd640;
    localparam logic [9:0] H_TOTAL   = 10'd800;
    localparam logic [9:0] V_VISIBLE = 10'd480;
    localparam logic [9:0] V_TOTAL   = 10'd525;

    localparam logic [7:0]        FB_LINE_WORDS = 8'd160;
    localparam logic [ADDR_W-1:0] FB_WORDS      = 16'd38400;

    // Slot phases within each 4-pixel group
    localparam logic [1:0] FETCH_PHASE = 2'd1;
    localparam logic [1:0] LOAD_PHASE  = 2'd3;
    localparam logic [9:0] NEXTLINE_H  = H_TOTAL - 10'd3;

    // Last H whose same-line fetch column (H>>2)+1 still lies inside the line (633)
    localparam logic [9:0] LAST_SAME_H = {FB_LINE_WORDS - 8'd2, FETCH_PHASE};

    // Word address of framebuffer row y, column fc: y*160 + fc as (y<<7)+(y<<5)+fc
    function automatic logic [ADDR_W-1:0] fb_addr(input logic [7:0] y, input logic [7:0] fc);
        logic [ADDR_W-1:0] y_w;
        y_w = {8'd0, y};
        return (y_w << 7) + (y_w << 5) + {8'd0, fc};
    endfunction

endpackage

// File: rtl/krypton_scan_addrgen.sv
// krypton_scan_addrgen
// Combinational scanout slot decoder. From the sync generator counters it
// decides whether the current cycle is a reserved scanout fetch slot and
// which framebuffer word to fetch.
// Ports:
//   hcount, vcount : H/V counters of the cycle being decided
//   fetch_en       : this cycle is a scanout fetch slot
//   fetch_addr     : VRAM word address to fetch (meaningful when fetch_en)
module krypton_scan_addrgen
    import krypton_vga_pkg::*;
(
    input  logic [9:0]        hcount,
    input  logic [9:0]        vcount,
    output logic              fetch_en,
    output logic [ADDR_W-1:0] fetch_addr
);

    logic [9:0] next_v_s;
    logic [9:0] line_s;
    logic [7:0] col_s;

    // Slot decode: next-line prefetch of column 0 near end of line, else same-line group prefetch
    always_comb begin
        next_v_s = (vcount == V_TOTAL - 10'd1) ? 10'd0 : vcount + 10'd1;
        fetch_en = 1'b0;
        line_s   = vcount;
        col_s    = 8'd0;
        if (hcount == NEXTLINE_H) begin
            line_s   = next_v_s;
            col_s    = 8'd0;
            fetch_en = (next_v_s < V_VISIBLE);
        end else if ((hcount[1:0] == FETCH_PHASE) && (hcount <= LAST_SAME_H) && (vcount < V_VISIBLE)) begin
            fetch_en = 1'b1;
            col_s    = hcount[9:2] + 8'd1;
        end else begin
            fetch_en = 1'b0;
        end
        // Each framebuffer row is shown on two consecutive display lines
        fetch_addr = fb_addr(line_s[8:1], col_s);
    end

endmodule

// File: rtl/krypton_vram_arbiter.sv
// krypton_vram_arbiter
// Shares a single-port, 1-cycle-latency VRAM between display scanout (fixed
// reserved slots) and a host write port (any non-scanout cycle), and turns
// the fetched words into a 2x-doubled 8bpp pixel stream.
// Ports:
//   i_Clk, i_Rst_n        : pixel clock, synchronous active-low reset
//   i_HCount, i_VCount    : sync generator counters
//   i_Host_Req/Addr/Data  : host write request (held until o_Host_Ack)
//   o_Host_Ack            : one-cycle pulse, request consumed
//   o_Mem_Addr/WrEn/WrData: registered VRAM command
//   i_Mem_RdData          : VRAM read data, one cycle after the address
//   o_Pixel, o_Pixel_Valid: pixel for the previous cycle's counters
module krypton_vram_arbiter
    import krypton_vga_pkg::*;
(
    input  logic              i_Clk,
    input  logic              i_Rst_n,
    input  logic [9:0]        i_HCount,
    input  logic [9:0]        i_VCount,
    input  logic              i_Host_Req,
    input  logic [ADDR_W-1:0] i_Host_Addr,
    input  logic [15:0]       i_Host_Data,
    output logic              o_Host_Ack,
    output logic [ADDR_W-1:0] o_Mem_Addr,
    output logic              o_Mem_WrEn,
    output logic [15:0]       o_Mem_WrData,
    input  logic [15:0]       i_Mem_RdData,
    output logic [7:0]        o_Pixel,
    output logic              o_Pixel_Valid
);

    logic              fetch_en_s;
    logic [ADDR_W-1:0] fetch_addr_s;
    logic              host_win_s;
    logic              visible_s;

    logic              ack_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic              mem_wren_r;
    logic [15:0]       mem_wrdata_r;
    logic              fetch_d1_r;
    logic              fetch_d2_r;
    logic [15:0]       cur_r;
    logic [7:0]        pixel_r;
    logic              pixel_valid_r;

    krypton_scan_addrgen u_addrgen (
        .hcount     (i_HCount),
        .vcount     (i_VCount),
        .fetch_en   (fetch_en_s),
        .fetch_addr (fetch_addr_s)
    );

    // Host wins non-scanout cycles; a request is ignored in its ack cycle to avoid double writes
    always_comb begin
        host_win_s = i_Host_Req && !ack_r && !fetch_en_s;
        visible_s  = (i_HCount < H_VISIBLE) && (i_VCount < V_VISIBLE);
    end

    // VRAM command register: scanout read, host write, or idle (address held)
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            mem_addr_r   <= 16'd0;
            mem_wren_r   <= 1'b0;
            mem_wrdata_r <= 16'd0;
            ack_r        <= 1'b0;
        end else begin
            ack_r <= host_win_s;
            if (fetch_en_s) begin
                mem_addr_r <= fetch_addr_s;
                mem_wren_r <= 1'b0;
            end else if (host_win_s) begin
                mem_addr_r   <= i_Host_Addr;
                mem_wrdata_r <= i_Host_Data;
                // Out-of-framebuffer writes are acknowledged but dropped
                mem_wren_r   <= (i_Host_Addr < FB_WORDS);
            end else begin
                mem_wren_r <= 1'b0;
            end
        end
    end

    // Track scanout reads through the VRAM latency and capture the returned word
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            fetch_d1_r <= 1'b0;
            fetch_d2_r <= 1'b0;
            cur_r      <= 16'd0;
        end else begin
            fetch_d1_r <= fetch_en_s;
            fetch_d2_r <= fetch_d1_r;
            // Phase gate keeps r_Cur aligned to its group even if the counters jump
            if (fetch_d2_r && (i_HCount[1:0] == LOAD_PHASE)) begin
                cur_r <= i_Mem_RdData;
            end
        end
    end

    // Pixel output: H[1] selects the byte, giving 2x horizontal doubling
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            pixel_r       <= 8'd0;
            pixel_valid_r <= 1'b0;
        end else if (visible_s) begin
            pixel_r       <= i_HCount[1] ? cur_r[15:8] : cur_r[7:0];
            pixel_valid_r <= 1'b1;
        end else begin
            pixel_r       <= 8'd0;
            pixel_valid_r <= 1'b0;
        end
    end

    assign o_Host_Ack    = ack_r;
    assign o_Mem_Addr    = mem_addr_r;
    assign o_Mem_WrEn    = mem_wren_r;
    assign o_Mem_WrData  = mem_wrdata_r;
    assign o_Pixel       = pixel_r;
    assign o_Pixel_Valid = pixel_valid_r;

endmodule
